load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: accepts one load/store per op from the pipeline MEM stage and drives a word-addressed, byte-enabled request/grant/response bus toward a variable-latency data memory or cache.
- Performs byte-lane alignment, byte-enable generation and load sign/zero extension for RV32I funct3 encodings (lb/lh/lw/lbu/lhu, sb/sh/sw).
- Splits word-crossing accesses into two bus beats and stalls the pipeline until the op completes.

---
 rtl/load_store_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store initiator onto a req/gnt/rvalid
// word bus. Aligns byte lanes, builds byte enables, splits word-crossing
// accesses into two beats and sign/zero-extends load data.
// Ports: clk, rst (sync, active-high); lsu_* pipeline side (valid, we,
// addr, wdata, funct3 in; stall, done, rdata, err out); mem_* bus side
// (req, we, addr, wdata, be out; gnt, rvalid, rdata in).
// Build option: MISALIGN_TRAP_EN makes word-crossing ops fail with err
// instead of being split into two beats.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [31:0]           lsu_wdata,
  input  logic [2:0]            lsu_funct3,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic [31:0]           lsu_rdata,
  output logic                  lsu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1) + 1;

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [7:0]            be_q, be_d;
  logic [63:0]           wd_q, wd_d;
  logic [31:0]           rd0_q, rd0_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic        legal;
  logic [3:0]  base_m;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        split;
  logic        beat1;
  logic        timeout;

  function automatic logic [31:0] extend(
    input logic [63:0] r64,
    input logic [1:0]  off,
    input logic [2:0]  f3
  );
    logic [31:0] r;
    r = 32'(r64 >> {off, 3'b000});
    unique case (f3)
      3'b000:  extend = {{24{r[7]}}, r[7:0]};
      3'b001:  extend = {{16{r[15]}}, r[15:0]};
      3'b100:  extend = {24'b0, r[7:0]};
      3'b101:  extend = {16'b0, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  // Size decode and lane placement of the op offered in IDLE
  always_comb begin
    legal  = 1'b0;
    base_m = 4'b0000;
    unique case (lsu_funct3)
      3'b000: begin legal = 1'b1;    base_m = 4'b0001; end
      3'b001: begin legal = 1'b1;    base_m = 4'b0011; end
      3'b010: begin legal = 1'b1;    base_m = 4'b1111; end
      3'b100: begin legal = !lsu_we; base_m = 4'b0001; end
      3'b101: begin legal = !lsu_we; base_m = 4'b0011; end
      default: ;
    endcase
    mask8  = {4'b0000, base_m} << lsu_addr[1:0];
    data64 = {32'b0, lsu_wdata} << {lsu_addr[1:0], 3'b000};
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    base_d    = base_q;
    be_d      = be_q;
    wd_d      = wd_q;
    rd0_d     = rd0_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    lsu_done  = 1'b0;
    lsu_rdata = '0;
    lsu_err   = 1'b0;
    lsu_stall = 1'b0;
    split     = |be_q[7:4];
    beat1     = (state_q == REQ1) || (state_q == WAIT1);
    // >= so a grant on the last allowed cycle still times out in WAIT
    timeout   = cnt_q >= CW'(MAX_WAIT - 1);

    unique case (state_q)
      IDLE: begin
        lsu_stall = lsu_valid;
        cnt_d     = '0;
        if (lsu_valid) begin
          we_d    = lsu_we;
          f3_d    = lsu_funct3;
          off_d   = lsu_addr[1:0];
          base_d  = {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
          be_d    = mask8;
          wd_d    = data64;
          rdata_d = '0;
          err_d   = 1'b0;
          if (!legal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`ifdef MISALIGN_TRAP_EN
          else if (|mask8[7:4]) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
          else begin
            state_d = REQ0;
          end
        end
      end
      REQ0, REQ1: begin
        lsu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = beat1 ? base_q + ADDR_WIDTH'(4) : base_q;
        mem_be    = beat1 ? be_q[7:4] : be_q[3:0];
        mem_wdata = beat1 ? wd_q[63:32] : wd_q[31:0];
        cnt_d     = cnt_q + CW'(1);
        if (mem_gnt) begin
          if (!we_q) begin
            state_d = beat1 ? WAIT1 : WAIT0;
          end else if (!beat1 && split) begin
            state_d = REQ1;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      WAIT0, WAIT1: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        if (mem_rvalid) begin
          if (!beat1 && split) begin
            rd0_d   = mem_rdata;
            state_d = REQ1;
            cnt_d   = '0;
          end else begin
            rdata_d = extend(beat1 ? {mem_rdata, rd0_q}
                                   : {32'b0, mem_rdata},
                             off_q, f3_q);
            state_d = DONE;
          end
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE: begin
        lsu_done  = 1'b1;
        lsu_rdata = rdata_q;
        lsu_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      base_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rd0_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      base_q  <= base_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd0_q   <= rd0_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors for load_store_unit with a
// simple grant/response bus model and hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [2:0]  lsu_funct3 = '0;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.ADDR_WIDTH(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_funct3(lsu_funct3),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus model: grant follows mem_req, read data one cycle after grant
  logic        gnt_en = 1'b1;
  logic        rv_en = 1'b1;
  logic        rv_force = 1'b0;
  logic [31:0] rd_words [2];
  int          rv_base = 0;
  int          rv_cnt = 0;
  int          beat_cnt = 0;
  int          req_cnt = 0;
  int          done_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] bt_addr [64];
  logic [3:0]  bt_be [64];
  logic [31:0] bt_wd [64];
  logic        bt_we [64];

  always @(negedge clk) begin
    mem_rvalid = (pend && rv_en) || rv_force;
    mem_rdata  = rd_words[1'(rv_cnt - rv_base)];
    if (mem_rvalid) rv_cnt++;
    if (mem_req) req_cnt++;
    if (lsu_done) done_cnt++;
    mem_gnt = mem_req && gnt_en;
    pend    = mem_gnt && !mem_we;
    if (mem_gnt) begin
      bt_addr[6'(beat_cnt)] = mem_addr;
      bt_be[6'(beat_cnt)]   = mem_be;
      bt_wd[6'(beat_cnt)]   = mem_wdata;
      bt_we[6'(beat_cnt)]   = mem_we;
      beat_cnt++;
    end
  end

  task automatic do_op(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output int lat, output logic [31:0] rd,
                       output logic er, output int b0, output int nb,
                       output int nreq);
    int   rq0;
    logic stall_ok;
    logic seen;
    @(negedge clk); #1;
    lsu_valid  = 1'b1;
    lsu_we     = we;
    lsu_addr   = addr;
    lsu_wdata  = wd;
    lsu_funct3 = f3;
    b0       = beat_cnt;
    rq0      = req_cnt;
    rv_base  = rv_cnt;
    lat      = 0;
    rd       = '0;
    er       = 1'b0;
    seen     = 1'b0;
    stall_ok = 1'b1;
    for (int n = 1; n <= 40 && !seen; n++) begin
      #1;
      if (lsu_done) begin
        seen = 1'b1;
        lat  = n;
        rd   = lsu_rdata;
        er   = lsu_err;
        if (lsu_stall) stall_ok = 1'b0;
      end else begin
        if (!lsu_stall) stall_ok = 1'b0;
        @(negedge clk); #1;
      end
    end
    lsu_valid = 1'b0;
    nb   = beat_cnt - b0;
    nreq = req_cnt - rq0;
    chk("stall", stall_ok, 1);
    chk("done_seen", seen, 1);
  endtask

  task automatic run(input string tag, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3, input logic [31:0] w0,
                     input logic [31:0] w1, input int e_lat,
                     input logic [31:0] e_rd, input logic e_err,
                     input int e_nb, output int b0, output int nreq);
    int          lat;
    int          nb;
    logic [31:0] rd;
    logic        er;
    rd_words[0] = w0;
    rd_words[1] = w1;
    do_op(we, addr, wd, f3, lat, rd, er, b0, nb, nreq);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_err"}, er, e_err);
    chk({tag, "_beats"}, nb, e_nb);
  endtask

  task automatic chk_beat(input string tag, input int i,
                          input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic we);
    chk({tag, "_addr"}, bt_addr[6'(i)], a);
    chk({tag, "_be"}, bt_be[6'(i)], be);
    chk({tag, "_wdata"}, bt_wd[6'(i)], wd);
    chk({tag, "_we"}, bt_we[6'(i)], we);
  endtask

  int b0;
  int nreq;
  int d0;

  initial begin
    rd_words[0] = '0;
    rd_words[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bus", {mem_req, mem_we, mem_be}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_lsu", {lsu_done, lsu_err, lsu_stall}, 0);
    chk("rst_rdata", lsu_rdata, 0);
    rst = 1'b0;

    run("lw", 0, 32'h10000, 0, 3'b010, 32'h8899AABB, 0,
        4, 32'h8899AABB, 0, 1, b0, nreq);
    chk_beat("lw_b0", b0, 32'h10000, 4'b1111, 0, 0);

    run("lb", 0, 32'h10003, 0, 3'b000, 32'h80112233, 0,
        4, 32'hFFFFFF80, 0, 1, b0, nreq);
    chk("lb_be", bt_be[6'(b0)], 4'b1000);
    run("lbu", 0, 32'h10003, 0, 3'b100, 32'h80112233, 0,
        4, 32'h00000080, 0, 1, b0, nreq);

    run("lh", 0, 32'h10002, 0, 3'b001, 32'hF00D1234, 0,
        4, 32'hFFFFF00D, 0, 1, b0, nreq);
    chk("lh_be", bt_be[6'(b0)], 4'b1100);
    run("lhu", 0, 32'h10002, 0, 3'b101, 32'hF00D1234, 0,
        4, 32'h0000F00D, 0, 1, b0, nreq);

    run("sw", 1, 32'h20004, 32'hDEADBEEF, 3'b010, 0, 0,
        3, 0, 0, 1, b0, nreq);
    chk_beat("sw_b0", b0, 32'h20004, 4'b1111, 32'hDEADBEEF, 1);

    run("sb", 1, 32'h10001, 32'h000000A5, 3'b000, 0, 0,
        3, 0, 0, 1, b0, nreq);
    chk_beat("sb_b0", b0, 32'h10000, 4'b0010, 32'h0000A500, 1);

`ifdef MISALIGN_TRAP_EN
    run("sh_x", 1, 32'h10003, 32'h0000BEEF, 3'b001, 0, 0,
        2, 0, 1, 0, b0, nreq);
    chk("sh_x_req", nreq, 0);
    run("lw_x", 0, 32'h10002, 0, 3'b010, 32'h44332211, 32'h88776655,
        2, 0, 1, 0, b0, nreq);
    chk("lw_x_req", nreq, 0);
`else
    run("sh_x", 1, 32'h10003, 32'h0000BEEF, 3'b001, 0, 0,
        4, 0, 0, 2, b0, nreq);
    chk_beat("sh_x_b0", b0, 32'h10000, 4'b1000, 32'hEF000000, 1);
    chk_beat("sh_x_b1", b0 + 1, 32'h10004, 4'b0001, 32'h000000BE, 1);
    run("lw_x", 0, 32'h10002, 0, 3'b010, 32'h44332211, 32'h88776655,
        6, 32'h66554433, 0, 2, b0, nreq);
    chk_beat("lw_x_b0", b0, 32'h10000, 4'b1100, 0, 0);
    chk_beat("lw_x_b1", b0 + 1, 32'h10004, 4'b0011, 0, 0);
    run("sh_wrap", 1, 32'hFFFFFFFF, 32'h00001234, 3'b001, 0, 0,
        4, 0, 0, 2, b0, nreq);
    chk_beat("wrap_b0", b0, 32'hFFFFFFFC, 4'b1000, 32'h34000000, 1);
    chk_beat("wrap_b1", b0 + 1, 32'h00000000, 4'b0001, 32'h00000012, 1);
`endif

    gnt_en = 1'b0;
    run("tmo", 0, 32'h10000, 0, 3'b010, 32'h12345678, 0,
        10, 0, 1, 0, b0, nreq);
    chk("tmo_req_cycles", nreq, 8);
    gnt_en = 1'b1;

    run("ill_ld", 0, 32'h10000, 0, 3'b011, 0, 0, 2, 0, 1, 0, b0, nreq);
    chk("ill_ld_req", nreq, 0);
    run("ill_st", 1, 32'h10000, 0, 3'b100, 0, 0, 2, 0, 1, 0, b0, nreq);
    chk("ill_st_req", nreq, 0);

    // Reset while parked in WAIT0, then a stale rvalid
    rv_en = 1'b0;
    @(negedge clk); #1;
    lsu_valid  = 1'b1;
    lsu_we     = 1'b0;
    lsu_addr   = 32'h10000;
    lsu_funct3 = 3'b010;
    @(negedge clk); #1;
    chk("mid_req", mem_req, 1);
    @(negedge clk); #1;
    chk("mid_wait", {mem_req, lsu_stall}, 2'b01);
    rst       = 1'b1;
    lsu_valid = 1'b0;
    rv_force  = 1'b1;
    d0        = done_cnt;
    @(negedge clk); #1;
    rst      = 1'b0;
    rv_force = 1'b0;
    chk("mid_rst_bus", {mem_req, mem_we, mem_be}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_rst_idle", {mem_req, lsu_stall, lsu_done, lsu_err}, 0);
      chk("post_rst_rdata", lsu_rdata, 0);
    end
    chk("post_rst_no_done", done_cnt - d0, 0);
    rv_en = 1'b1;

    run("lw_after", 0, 32'h30008, 0, 3'b010, 32'hCAFEF00D, 0,
        4, 32'hCAFEF00D, 0, 1, b0, nreq);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
